axil_cmd_master: RTL



---
 rtl/axil_pkg.sv | 32 +++
 rtl/axil_skid_hold.sv | 47 ++++
 rtl/axil_cmd_master.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite command master:
//   - AXI response encodings (OKAY / EXOKAY / SLVERR / DECERR)
//   - the command-master FSM state type
//   - the protection value driven on AWPROT / ARPROT
// Build option: AXIL_TIMEOUT_EN adds the DRAIN state used to clean up
// after a response timeout.
// ---------------------------------------------------------------------------
package axil_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Unprivileged, secure, data access.
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RDATA,
        RESP
`ifdef AXIL_TIMEOUT_EN
        , DRAIN
`endif
    } axil_state_e;

endpackage

// File: rtl/axil_skid_hold.sv
// ---------------------------------------------------------------------------
// axil_skid_hold
// Single-entry valid/payload holding register for one AXI request channel
// (AW, W or AR). A load raises VALID with a fresh payload; VALID then stays
// high with a frozen payload until the partner's READY is seen.
// Ports:
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   load_i     capture payload_i and raise valid_o
//   payload_i  payload to capture
//   ready_i    channel READY from the partner
//   valid_o    registered channel VALID
//   payload_o  registered channel payload
// ---------------------------------------------------------------------------
module axil_skid_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] payload_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] payload_o
);

    logic             valid_q;
    logic [WIDTH-1:0] payload_q;

    // The payload only changes on a load; the owner never loads while VALID
    // is still up, so the payload is stable for the whole VALID period.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (load_i) begin
            valid_q   <= 1'b1;
            payload_q <= payload_i;
        end else if (valid_q && ready_i) begin
            valid_q   <= 1'b0;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/axil_cmd_master.sv
// ---------------------------------------------------------------------------
// axil_cmd_master
// AXI4-Lite master turning a valid/ready register-command stream into single
// AXI4-Lite reads or writes, one outstanding at a time, returning each result
// on a valid/ready response stream. Every output is a register.
// Ports:
//   M_AXI_ACLK / M_AXI_ARESETN   clock, synchronous active-low reset
//   cmd_*                        command stream (write flag, addr, data, strb)
//   rsp_*                        response stream (read data, AXI resp code)
//   M_AXI_AW* / W* / B*          AXI4-Lite write address / data / response
//   M_AXI_AR* / R*               AXI4-Lite read address / data
// Build option: AXIL_TIMEOUT_EN enables a response timeout. A stalled
// transaction is reported with DECERR and the late AXI traffic is drained
// before new commands are taken. Without it the FSM waits indefinitely.
// ---------------------------------------------------------------------------
module axil_cmd_master #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      M_AXI_ACLK,
    input  logic                      M_AXI_ARESETN,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    import axil_pkg::*;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    axil_state_e           state_q;
    logic                  cmdReady_q;
    logic                  bReady_q;
    logic                  rReady_q;
    logic                  rspValid_q;
    logic [DATA_WIDTH-1:0] rspRdata_q;
    logic [1:0]            rspResp_q;

    logic cmdAccept;
    logic loadWrite;
    logic loadRead;
    logic awValid;
    logic wValid;
    logic arValid;
    logic awDone;
    logic wDone;
    logic arDone;
    logic arHs;
    logic bHs;
    logic rHs;

    // A command is taken only while IDLE is advertising cmd_ready; the
    // acceptance loads the request channels directly so their VALIDs rise
    // on the same edge the FSM leaves IDLE.
    assign cmdAccept = (state_q == IDLE) && cmdReady_q && cmd_valid;
    assign loadWrite = cmdAccept && cmd_write;
    assign loadRead  = cmdAccept && !cmd_write;

    axil_skid_hold #(.WIDTH(ADDR_WIDTH)) u_awHold (
        .clk_i     (M_AXI_ACLK),
        .rst_ni    (M_AXI_ARESETN),
        .load_i    (loadWrite),
        .payload_i (cmd_addr),
        .ready_i   (M_AXI_AWREADY),
        .valid_o   (awValid),
        .payload_o (M_AXI_AWADDR)
    );

    axil_skid_hold #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_wHold (
        .clk_i     (M_AXI_ACLK),
        .rst_ni    (M_AXI_ARESETN),
        .load_i    (loadWrite),
        .payload_i ({cmd_wstrb, cmd_wdata}),
        .ready_i   (M_AXI_WREADY),
        .valid_o   (wValid),
        .payload_o ({M_AXI_WSTRB, M_AXI_WDATA})
    );

    axil_skid_hold #(.WIDTH(ADDR_WIDTH)) u_arHold (
        .clk_i     (M_AXI_ACLK),
        .rst_ni    (M_AXI_ARESETN),
        .load_i    (loadRead),
        .payload_i (cmd_addr),
        .ready_i   (M_AXI_ARREADY),
        .valid_o   (arValid),
        .payload_o (M_AXI_ARADDR)
    );

    // A channel counts as done once its VALID has dropped, or when its
    // handshake is happening this very cycle. AW and W finish independently.
    assign awDone = !awValid || M_AXI_AWREADY;
    assign wDone  = !wValid  || M_AXI_WREADY;
    assign arDone = !arValid || M_AXI_ARREADY;
    assign arHs   = arValid && M_AXI_ARREADY;
    assign bHs    = M_AXI_BVALID && bReady_q;
    assign rHs    = M_AXI_RVALID && rReady_q;

`ifdef AXIL_TIMEOUT_EN
    logic [15:0] timer_q;
    logic        drainPending_q;
    logic        drainWrite_q;
    logic        inWait;
    logic        anyHs;
    logic        stepDone;
    logic        timeoutHit;

    assign inWait     = (state_q == WRITE) || (state_q == WRESP) ||
                        (state_q == READ)  || (state_q == RDATA);
    assign anyHs      = (awValid && M_AXI_AWREADY) || (wValid && M_AXI_WREADY) ||
                        arHs || bHs || rHs;
    assign timeoutHit = (timer_q >= 16'(TIMEOUT_CYCLES));

    // Whether the current waiting state makes forward progress this cycle;
    // progress always wins over a timeout landing on the same edge.
    always_comb begin
        stepDone = 1'b0;
        case (state_q)
            WRITE:   stepDone = awDone && wDone;
            WRESP:   stepDone = bHs;
            READ:    stepDone = arHs;
            RDATA:   stepDone = rHs;
            default: stepDone = 1'b0;
        endcase
    end
`else
    // The timeout length has no effect unless AXIL_TIMEOUT_EN is defined.
    if (TIMEOUT_CYCLES > 0) begin : g_noTimeout
    end
`endif

    // Main sequencer. Holds the command/response handshake flags and the
    // B/R READYs as registers so no input reaches an output combinationally.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q    <= IDLE;
            cmdReady_q <= 1'b0;
            bReady_q   <= 1'b0;
            rReady_q   <= 1'b0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspResp_q  <= OKAY;
`ifdef AXIL_TIMEOUT_EN
            timer_q        <= '0;
            drainPending_q <= 1'b0;
            drainWrite_q   <= 1'b0;
`endif
        end else begin
`ifdef AXIL_TIMEOUT_EN
            // Entering a waiting state always comes through a handshake or
            // from IDLE, both of which leave the counter at zero.
            if (inWait && !anyHs) begin
                timer_q <= timer_q + 16'd1;
            end else begin
                timer_q <= '0;
            end
`endif
            case (state_q)
                IDLE: begin
                    // Coming out of reset or RESP/DRAIN with cmd_ready low,
                    // the first IDLE cycle only raises cmd_ready.
                    if (!cmdReady_q) begin
                        cmdReady_q <= 1'b1;
                    end else if (cmd_valid) begin
                        cmdReady_q <= 1'b0;
                        state_q    <= cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (awDone && wDone) begin
                        bReady_q <= 1'b1;
                        state_q  <= WRESP;
                    end
                end
                WRESP: begin
                    if (bHs) begin
                        rspResp_q  <= M_AXI_BRESP;
                        rspRdata_q <= '0;
                        bReady_q   <= 1'b0;
                        rspValid_q <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                READ: begin
                    if (arHs) begin
                        rReady_q <= 1'b1;
                        state_q  <= RDATA;
                    end
                end
                RDATA: begin
                    if (rHs) begin
                        rspRdata_q <= M_AXI_RDATA;
                        rspResp_q  <= M_AXI_RRESP;
                        rReady_q   <= 1'b0;
                        rspValid_q <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
`ifdef AXIL_TIMEOUT_EN
                        if (drainPending_q) begin
                            state_q <= DRAIN;
                        end else begin
                            cmdReady_q <= 1'b1;
                            state_q    <= IDLE;
                        end
`else
                        cmdReady_q <= 1'b1;
                        state_q    <= IDLE;
`endif
                    end
                end
`ifdef AXIL_TIMEOUT_EN
                DRAIN: begin
                    // Request VALIDs keep running in their hold registers;
                    // once they are done, accept and discard the late reply.
                    if (drainWrite_q) begin
                        if (!bReady_q) begin
                            if (awDone && wDone) begin
                                bReady_q <= 1'b1;
                            end
                        end else if (M_AXI_BVALID) begin
                            bReady_q       <= 1'b0;
                            drainPending_q <= 1'b0;
                            state_q        <= IDLE;
                        end
                    end else begin
                        if (!rReady_q) begin
                            if (arDone) begin
                                rReady_q <= 1'b1;
                            end
                        end else if (M_AXI_RVALID) begin
                            rReady_q       <= 1'b0;
                            drainPending_q <= 1'b0;
                            state_q        <= IDLE;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
`ifdef AXIL_TIMEOUT_EN
            // Timeout: report DECERR now and finish the AXI side in DRAIN.
            // B/R READY drop here and are raised again only in DRAIN, so a
            // late reply cannot be accepted while the error is pending.
            if (inWait && !stepDone && timeoutHit) begin
                rspResp_q      <= DECERR;
                rspRdata_q     <= '0;
                rspValid_q     <= 1'b1;
                bReady_q       <= 1'b0;
                rReady_q       <= 1'b0;
                drainPending_q <= 1'b1;
                drainWrite_q   <= (state_q == WRITE) || (state_q == WRESP);
                state_q        <= RESP;
            end
`endif
        end
    end

    assign cmd_ready     = cmdReady_q;
    assign rsp_valid     = rspValid_q;
    assign rsp_rdata     = rspRdata_q;
    assign rsp_resp      = rspResp_q;
    assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_AWVALID = awValid;
    assign M_AXI_WVALID  = wValid;
    assign M_AXI_ARVALID = arValid;
    assign M_AXI_BREADY  = bReady_q;
    assign M_AXI_RREADY  = rReady_q;

endmodule
